lsu_arbiter: RTL and testbench

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arb_pkg.sv | 32 +++
 rtl/lsu_arb_pick.sv | 30 +++
 rtl/lsu_arbiter.sv | 158 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-port LSU arbiter: FSM state, LSU size codes,
// registered command, and the alignment rule.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } arb_cmd_t;

  // Unsigned variants share the low two size bits with their signed forms.
  function automatic logic misaligned(input logic [2:0] size, input logic [31:0] addr);
    return ((size[1:0] == SZ_H[1:0]) && addr[0]) ||
           ((size[1:0] == SZ_W[1:0]) && (addr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_arb_pick.sv
// Winner selection: lock mask, then round-robin (LSU_ARB_RR_EN defined) or
// fixed priority with requester 0 ahead of requester 1.
module lsu_arb_pick
  import lsu_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       locked_i,
  input  logic       owner_i,
`ifdef LSU_ARB_RR_EN
  input  logic       rr_ptr_i,
`endif
  output logic [1:0] gnt_o
);

  logic [1:0] cand;

  always_comb begin
    cand = valid_i;
    if (locked_i) cand = valid_i & (owner_i ? 2'b10 : 2'b01);
    gnt_o = cand;
    if (cand == 2'b11) begin
`ifdef LSU_ARB_RR_EN
      gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
`else
      gnt_o = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester LSU arbiter: IDLE/ACCESS/RESP sequencer with grant lock and
// lock timeout. Define LSU_ARB_RR_EN for round-robin, else fixed priority.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  input  logic        req0_we_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  input  logic [2:0]  req0_size_i,
  input  logic        req0_lock_i,
  input  logic        req1_valid_i,
  input  logic        req1_we_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  input  logic [2:0]  req1_size_i,
  input  logic        req1_lock_i,
  output logic        req0_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_rdata_o,
  output logic        rsp0_err_o,
  output logic        req1_ready_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_rdata_o,
  output logic        rsp1_err_o,
  output logic [31:0] lsu_addr_o,
  output logic        lsu_st_en_o,
  output logic [31:0] lsu_st_data_o,
  output logic [2:0]  lsu_sel_mod_o,
  input  logic [31:0] lsu_ld_data_i,
  output logic        lock_timeout_o
);

  localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);

  arb_state_e       state_q;
  arb_cmd_t         cmd_q;
  logic             locked_q, owner_q, timeout_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       rsp_vld_q;
  logic [31:0]      rdata_q;

  logic [1:0]  valid, gnt, ready;
  logic        acc_any, win, own_valid, idle_wait, in_access;
  logic        sel_we, sel_lock;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_size;

`ifdef LSU_ARB_RR_EN
  logic rr_q;
`endif

  assign valid = {req1_valid_i, req0_valid_i};

  lsu_arb_pick u_pick (
    .valid_i  (valid),
    .locked_i (locked_q),
    .owner_i  (owner_q),
`ifdef LSU_ARB_RR_EN
    .rr_ptr_i (rr_q),
`endif
    .gnt_o    (gnt)
  );

  // Grants are only offered outside ACCESS and never while reset is held.
  assign in_access = (state_q == ACCESS);
  assign ready     = gnt & {2{rst_ni && !in_access}};
  assign acc_any   = |ready;
  assign win       = ready[1];

  assign sel_we    = win ? req1_we_i    : req0_we_i;
  assign sel_lock  = win ? req1_lock_i  : req0_lock_i;
  assign sel_addr  = win ? req1_addr_i  : req0_addr_i;
  assign sel_wdata = win ? req1_wdata_i : req0_wdata_i;
  assign sel_size  = win ? req1_size_i  : req0_size_i;

  assign own_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign idle_wait = (state_q == IDLE) && locked_q && !own_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      locked_q  <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      rsp_vld_q <= '0;
`ifdef LSU_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      timeout_q <= 1'b0;
      rsp_vld_q <= '0;
      if (in_access) begin
        state_q <= RESP;
        rsp_vld_q[cmd_q.owner] <= 1'b1;
      end else begin
        state_q <= acc_any ? ACCESS : IDLE;
      end
      if (acc_any) begin
        cnt_q <= '0;
        if (sel_lock) begin
          locked_q <= 1'b1;
          owner_q  <= win;
        end else begin
          locked_q <= 1'b0;
        end
`ifdef LSU_ARB_RR_EN
        rr_q <= ~win;
`endif
      end else if (idle_wait) begin
        if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          locked_q  <= 1'b0;
          cnt_q     <= '0;
          timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Datapath registers carry no reset; every consumer is qualified by state.
  always_ff @(posedge clk_i) begin
    if (acc_any) begin
      cmd_q.owner <= win;
      cmd_q.we    <= sel_we;
      cmd_q.err   <= misaligned(sel_size, sel_addr);
      cmd_q.addr  <= sel_addr;
      cmd_q.wdata <= sel_wdata;
      cmd_q.size  <= sel_size;
    end
    if (in_access) begin
      rdata_q <= (cmd_q.we || cmd_q.err) ? '0 : lsu_ld_data_i;
      err_q   <= cmd_q.err;
    end
  end

  assign lsu_addr_o    = in_access ? cmd_q.addr  : '0;
  assign lsu_st_data_o = in_access ? cmd_q.wdata : '0;
  assign lsu_sel_mod_o = in_access ? cmd_q.size  : '0;
  assign lsu_st_en_o   = in_access && cmd_q.we && !cmd_q.err;

  assign req0_ready_o   = ready[0];
  assign req1_ready_o   = ready[1];
  assign rsp0_valid_o   = rsp_vld_q[0];
  assign rsp1_valid_o   = rsp_vld_q[1];
  assign rsp0_rdata_o   = rsp_vld_q[0] ? rdata_q : '0;
  assign rsp1_rdata_o   = rsp_vld_q[1] ? rdata_q : '0;
  assign rsp0_err_o     = rsp_vld_q[0] && err_q;
  assign rsp1_err_o     = rsp_vld_q[1] && err_q;
  assign lock_timeout_o = timeout_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: the driver predicts grants and responses
// from a transaction-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  localparam int LM = 16;

  typedef struct {
    logic v; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] size; logic lock;
  } req_t;
  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; logic st; logic [31:0] wdata; logic [2:0] size; } lsu_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  req_t rq0, rq1;

  logic        req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata, lsu_addr, lsu_st_data, lsu_ld_data;
  logic        lsu_st_en, lock_timeout;
  logic [2:0]  lsu_sel_mod;
  logic [138:0] all_outs;

  lsu_arbiter #(.LOCK_MAX(LM)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(rq0.v), .req0_we_i(rq0.we), .req0_addr_i(rq0.addr),
    .req0_wdata_i(rq0.wdata), .req0_size_i(rq0.size), .req0_lock_i(rq0.lock),
    .req1_valid_i(rq1.v), .req1_we_i(rq1.we), .req1_addr_i(rq1.addr),
    .req1_wdata_i(rq1.wdata), .req1_size_i(rq1.size), .req1_lock_i(rq1.lock),
    .req0_ready_o(req0_ready), .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
    .req1_ready_o(req1_ready), .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
    .lsu_addr_o(lsu_addr), .lsu_st_en_o(lsu_st_en), .lsu_st_data_o(lsu_st_data),
    .lsu_sel_mod_o(lsu_sel_mod), .lsu_ld_data_i(lsu_ld_data), .lock_timeout_o(lock_timeout)
  );

  assign all_outs = {req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata,
                     rsp1_err, lsu_addr, lsu_st_en, lsu_st_data, lsu_sel_mod, lock_timeout};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device behind the LSU port: word-wide, 16 words.
  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction
  bit [31:0] dev_mem [16];
  bit [15:0] dev_wr;
  int n_writes = 0;
  always @(posedge clk) begin
    if (lsu_st_en) begin
      dev_mem[lsu_addr[5:2]] <= lsu_st_data;
      dev_wr[lsu_addr[5:2]]  <= 1'b1;
      n_writes <= n_writes + 1;
    end
  end
  assign lsu_ld_data = dev_wr[lsu_addr[5:2]] ? dev_mem[lsu_addr[5:2]] : init_word(int'(lsu_addr[5:2]));

  int n_checks = 0, n_pass = 0;
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state
  rsp_t expq0[$], expq1[$];
  lsu_t lsuq[$];
  logic [31:0] ref_mem [16];
  bit   acc_p1, acc_p2, m_locked, m_to_exp, pend_v;
  int   m_owner, m_cnt;
  logic [3:0]  pend_idx;
  logic [31:0] pend_data;
`ifdef LSU_ARB_RR_EN
  int m_last;
`endif

  task automatic model_reset();
    expq0.delete(); expq1.delete(); lsuq.delete();
    acc_p1 = 0; acc_p2 = 0; m_locked = 0; m_to_exp = 0; pend_v = 0; m_owner = 0; m_cnt = 0;
`ifdef LSU_ARB_RR_EN
    m_last = 1;
`endif
  endtask

  task automatic accept(input req_t r, input int w);
    rsp_t e; lsu_t l; bit mis;
    mis = ((r.size[1:0] == 2'b01) && (r.addr % 2 != 0)) || ((r.size[1:0] == 2'b10) && (r.addr % 4 != 0));
    l.cyc = cyc + 1; l.addr = r.addr; l.st = r.we && !mis; l.wdata = r.wdata; l.size = r.size;
    lsuq.push_back(l);
    e.cyc = cyc + 2; e.err = mis;
    e.rdata = (mis || r.we) ? 32'h0 : ref_mem[r.addr[5:2]];
    if (w == 0) expq0.push_back(e); else expq1.push_back(e);
    if (r.we && !mis) begin pend_v = 1; pend_idx = r.addr[5:2]; pend_data = r.wdata; end
    if (r.lock) begin m_locked = 1; m_owner = w; end else m_locked = 0;
    m_cnt = 0;
`ifdef LSU_ARB_RR_EN
    m_last = w;
`endif
  endtask

  // One clock cycle: drive, predict grant, compare, update model.
  task automatic step(input req_t a, input req_t b, output int win);
    bit c0, c1, in_idle;
    @(negedge clk);
    if (pend_v) begin ref_mem[pend_idx] = pend_data; pend_v = 0; end
    rq0 = a; rq1 = b;
    #1;
    in_idle = !acc_p1 && !acc_p2;
    c0 = a.v && (!m_locked || m_owner == 0);
    c1 = b.v && (!m_locked || m_owner == 1);
    win = -1;
    if (!acc_p1) begin
      if (c0 && c1) begin
`ifdef LSU_ARB_RR_EN
        win = (m_last == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else if (c0) win = 0;
      else if (c1) win = 1;
    end
    chk("ready0", 160'(req0_ready), 160'(win == 0));
    chk("ready1", 160'(req1_ready), 160'(win == 1));
    chk("lock_timeout", 160'(lock_timeout), 160'(m_to_exp));
    m_to_exp = 0;
    if (win >= 0) accept(win == 0 ? a : b, win);
    else if (in_idle && m_locked && !(m_owner == 0 ? a.v : b.v)) begin
      m_cnt++;
      if (m_cnt == LM) begin m_locked = 0; m_cnt = 0; m_to_exp = 1; end
    end
    acc_p2 = acc_p1; acc_p1 = (win >= 0);
  endtask

  // Monitor
  int rsp_seen = 0;
  logic [31:0] last_rdata0 = '0, last_rdata1 = '0;
  logic last_err1 = 1'b0;
  always @(negedge clk) begin : mon
    rsp_t e; lsu_t l;
    if (rsp0_valid) begin
      rsp_seen++; last_rdata0 = rsp0_rdata;
      if (expq0.size() == 0) chk("rsp0_unexpected", 160'(1), 160'(0));
      else begin
        e = expq0.pop_front();
        chk("rsp0_cycle", 160'(cyc), 160'(e.cyc));
        chk("rsp0_rdata", 160'(rsp0_rdata), 160'(e.rdata));
        chk("rsp0_err", 160'(rsp0_err), 160'(e.err));
      end
    end
    if (rsp1_valid) begin
      rsp_seen++; last_rdata1 = rsp1_rdata; last_err1 = rsp1_err;
      if (expq1.size() == 0) chk("rsp1_unexpected", 160'(1), 160'(0));
      else begin
        e = expq1.pop_front();
        chk("rsp1_cycle", 160'(cyc), 160'(e.cyc));
        chk("rsp1_rdata", 160'(rsp1_rdata), 160'(e.rdata));
        chk("rsp1_err", 160'(rsp1_err), 160'(e.err));
      end
    end
    if (lsuq.size() != 0 && lsuq[0].cyc == cyc) begin
      l = lsuq.pop_front();
      chk("lsu_addr", 160'(lsu_addr), 160'(l.addr));
      chk("lsu_st_en", 160'(lsu_st_en), 160'(l.st));
      chk("lsu_sel_mod", 160'(lsu_sel_mod), 160'(l.size));
      if (l.st) chk("lsu_st_data", 160'(lsu_st_data), 160'(l.wdata));
    end else begin
      chk("lsu_idle", 160'({lsu_st_en, lsu_addr, lsu_st_data, lsu_sel_mod}), 160'(0));
    end
  end

  function automatic req_t mk(input logic v, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] size, input logic lock);
    req_t r;
    r.v = v; r.we = we; r.addr = addr; r.wdata = wdata; r.size = size; r.lock = lock;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [2:0] sizes [5];
    sizes[0] = SZ_B; sizes[1] = SZ_H; sizes[2] = SZ_W; sizes[3] = SZ_BU; sizes[4] = SZ_HU;
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
              $urandom, sizes[$urandom_range(0, 4)], $urandom_range(0, 7) == 0);
  endfunction

  task automatic hold_reset(input int n);
    rq0 = mk(1, 0, 32'h4, 32'h0, SZ_W, 0);
    rq1 = mk(1, 1, 32'h8, 32'h55, SZ_W, 0);
    rst_ni = 1'b0;
    model_reset();
    #1 chk("reset_outputs", 160'(all_outs), 160'(0));
    repeat (n) @(negedge clk);
    #1 chk("reset_hold_outputs", 160'(all_outs), 160'(0));
    rq0.v = 0; rq1.v = 0;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    req_t noreq, a, b;
    int w, nw, rs, lock_cyc, nacc, prev;
    int wins[$];
    noreq = mk(0, 0, 0, 0, SZ_W, 0);
    rq0 = noreq; rq1 = noreq;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    hold_reset(3);

    // store W then load W from the same word, load accepted in RESP
    step(mk(1, 1, 32'h10, 32'hDEADBEEF, SZ_W, 0), noreq, w);
    chk("st_accept", 160'(w), 160'(0));
    a = mk(1, 0, 32'h10, 32'h0, SZ_W, 0);
    step(a, noreq, w);
    step(a, noreq, w);
    chk("ld_accept_in_resp", 160'(w), 160'(0));
    repeat (4) step(noreq, noreq, w);
    chk("ld_after_st_data", 160'(last_rdata0), 160'(32'hDEADBEEF));

    // both requesters valid every cycle
    hold_reset(2);
    for (int i = 0; i < 8; i++) begin
      step(mk(1, 0, 32'h0, 0, SZ_W, 0), mk(1, 0, 32'h4, 0, SZ_W, 0), w);
      if (w >= 0) wins.push_back(w);
    end
    repeat (4) step(noreq, noreq, w);
    chk("contend_count", 160'(wins.size()), 160'(4));
    for (int i = 0; i < 4 && i < wins.size(); i++) begin
`ifdef LSU_ARB_RR_EN
      chk("contend_grant", 160'(wins[i]), 160'(i % 2));
`else
      chk("contend_grant", 160'(wins[i]), 160'(0));
`endif
    end

    // misaligned halfword load on requester 1
    step(noreq, mk(1, 0, 32'h3, 0, SZ_H, 0), w);
    chk("mis_accept", 160'(w), 160'(1));
    repeat (4) step(noreq, noreq, w);
    chk("mis_err", 160'(last_err1), 160'(1));
    chk("mis_rdata", 160'(last_rdata1), 160'(0));

    // lock held by idle requester 1 until timeout
    step(noreq, mk(1, 0, 32'h8, 0, SZ_W, 1), w);
    chk("lock_accept", 160'(w), 160'(1));
    lock_cyc = cyc;
    w = -1;
    for (int i = 0; i < LM + 20 && w != 0; i++) step(mk(1, 0, 32'hC, 0, SZ_W, 0), noreq, w);
    chk("lock_grant", 160'(w), 160'(0));
    chk("lock_idle_denials", 160'(cyc - lock_cyc - 3), 160'(LM));
    chk("lock_timeout_at_grant", 160'(lock_timeout), 160'(1));
    repeat (4) step(noreq, noreq, w);

    // reset during ACCESS of a store
    step(mk(1, 1, 32'h20, 32'h12345678, SZ_W, 0), noreq, w);
    chk("rst_st_accept", 160'(w), 160'(0));
    nw = n_writes; rs = rsp_seen;
    @(negedge clk);
    #2;
    hold_reset(2);
    repeat (5) step(noreq, noreq, w);
    chk("rst_no_write", 160'(n_writes), 160'(nw));
    chk("rst_no_rsp", 160'(rsp_seen), 160'(rs));

    // back-to-back loads on requester 0
    nacc = 0; prev = -1;
    for (int i = 0; i < 20 && nacc < 6; i++) begin
      step(mk(1, 0, 32'(4 * nacc + 32), 0, SZ_W, 0), noreq, w);
      if (w == 0) begin
        if (prev >= 0) chk("b2b_spacing", 160'(cyc - prev), 160'(2));
        prev = cyc; nacc++;
      end
    end
    chk("b2b_count", 160'(nacc), 160'(6));
    repeat (4) step(noreq, noreq, w);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = rand_req(); b = rand_req();
      step(a, b, w);
    end
    repeat (5) step(noreq, noreq, w);
    chk("drain_rsp0", 160'(expq0.size()), 160'(0));
    chk("drain_rsp1", 160'(expq1.size()), 160'(0));
    chk("drain_lsu", 160'(lsuq.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
